// File: rtl/fan_speed_controller.sv
// Fan speed controller: button-driven level FSM, kick-start burst and period-aligned duty ramp feeding a registered PWM.
// Define FAN_SOFTSTART_EN to ramp by RAMP_STEP per period; otherwise the ramp jumps to the target in one boundary.
module fan_speed_controller (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_counter,
    input  logic       i_speed_up,
    input  logic       i_off,
    output logic       o_pwm,
    output logic [1:0] o_level,
    output logic [9:0] o_duty,
    output logic       o_busy
);
    localparam int unsigned CNT_W        = 10;
    localparam int unsigned KICK_W       = 3;
    localparam int unsigned PERIOD_MAX   = 999;
    localparam int unsigned DUTY_LOW     = 300;
    localparam int unsigned DUTY_MID     = 600;
    localparam int unsigned DUTY_HIGH    = 900;
    localparam int unsigned KICK_DUTY    = 999;
    localparam int unsigned KICK_PERIODS = 4;
`ifdef FAN_SOFTSTART_EN
    localparam int unsigned RAMP_STEP    = 50;
    localparam int unsigned SUM_W        = CNT_W + 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  duty_next;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  step_result;
    logic [KICK_W-1:0] kick_cnt;
    logic [KICK_W-1:0] kick_next;
    logic [1:0]        level_next;
    logic              pending;
    logic              pending_next;
    logic              boundary;
`ifdef FAN_SOFTSTART_EN
    logic [SUM_W-1:0]  up_sum;
    logic [SUM_W-1:0]  down_floor;
`endif

    assign boundary = (i_counter == CNT_W'(PERIOD_MAX));

    // User level: off pulse has priority over speed-up
    always_comb begin
        level_next = o_level;
        if (i_off) begin
            level_next = 2'd0;
        end else if (i_speed_up) begin
            level_next = o_level + 2'd1;
        end
    end

    // Remembers that the level left OFF since the last boundary; a leave on the boundary edge itself survives
    always_comb begin
        pending_next = pending;
        if (boundary) begin
            pending_next = 1'b0;
        end
        if (o_level == 2'd0 && level_next != 2'd0) begin
            pending_next = 1'b1;
        end
    end

    always_comb begin
        case (o_level)
            2'd1:    target = CNT_W'(DUTY_LOW);
            2'd2:    target = CNT_W'(DUTY_MID);
            2'd3:    target = CNT_W'(DUTY_HIGH);
            default: target = '0;
        endcase
    end

    // One ramp step from the current duty toward the target, clamped so it never overshoots
    always_comb begin
`ifdef FAN_SOFTSTART_EN
        up_sum     = {1'b0, o_duty} + SUM_W'(RAMP_STEP);
        down_floor = {1'b0, target} + SUM_W'(RAMP_STEP);
        if (o_duty < target) begin
            step_result = (up_sum > {1'b0, target}) ? target : up_sum[CNT_W-1:0];
        end else if ({1'b0, o_duty} > down_floor) begin
            step_result = o_duty - CNT_W'(RAMP_STEP);
        end else begin
            step_result = target;
        end
`else
        step_result = target;
`endif
    end

    // Duty FSM; only boundaries move it. Target is 0 when OFF, so a kick abort is an ordinary step.
    always_comb begin
        state_next = state;
        duty_next  = o_duty;
        kick_next  = kick_cnt;
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (pending && o_duty == '0 && o_level != 2'd0) begin
                        duty_next  = CNT_W'(KICK_DUTY);
                        kick_next  = KICK_W'(KICK_PERIODS);
                        state_next = KICK;
                    end else if (o_duty != target) begin
                        duty_next  = step_result;
                        state_next = (step_result == target) ? IDLE : RAMP;
                    end
                end
                KICK: begin
                    if (o_level == 2'd0 || kick_cnt == KICK_W'(1)) begin
                        kick_next  = '0;
                        duty_next  = step_result;
                        state_next = (step_result == target) ? IDLE : RAMP;
                    end else begin
                        kick_next = kick_cnt - KICK_W'(1);
                    end
                end
                RAMP: begin
                    duty_next  = step_result;
                    state_next = (step_result == target) ? IDLE : RAMP;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            o_duty   <= '0;
            kick_cnt <= '0;
            o_level  <= '0;
            pending  <= 1'b0;
            o_pwm    <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_next;
            o_duty   <= duty_next;
            kick_cnt <= kick_next;
            o_level  <= level_next;
            pending  <= pending_next;
            o_pwm    <= (i_counter < o_duty);
            o_busy   <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_fan_speed_controller.sv
// Bench for fan_speed_controller: directed scenarios plus random button traffic, scored per cycle against a period-level model.
module tb_fan_speed_controller;
    localparam int PERIOD_MAX   = 999;
    localparam int KICK_DUTY    = 999;
    localparam int KICK_PERIODS = 4;
    localparam int RAMP_STEP    = 50;
`ifdef FAN_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif
    localparam int RAND_CYCLES  = SOFT ? 5000 : 15000;

    logic       clk;
    logic       rst;
    logic [9:0] cnt;
    logic       up;
    logic       off;
    logic       pwm;
    logic [1:0] level;
    logic [9:0] duty;
    logic       busy;

    typedef struct {
        int level;
        int duty;
        bit busy;
        bit pwm;
    } obs_t;

    obs_t exp_q[$];
    int   checks;
    int   errors;

    // Reference model state: what the user chose and where the fan duty currently sits
    int m_level;
    int m_duty;
    int m_kick;
    bit m_ramp;
    bit m_pend;
    bit m_pwm;

    fan_speed_controller dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_counter  (cnt),
        .i_speed_up (up),
        .i_off      (off),
        .o_pwm      (pwm),
        .o_level    (level),
        .o_duty     (duty),
        .o_busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int target_of(int lv);
        case (lv)
            1:       return 300;
            2:       return 600;
            3:       return 900;
            default: return 0;
        endcase
    endfunction

    function automatic int approach(int d, int t);
        if (!SOFT) return t;
        if (d < t) return (d + RAMP_STEP > t) ? t : d + RAMP_STEP;
        return (d - RAMP_STEP < t) ? t : d - RAMP_STEP;
    endfunction

    task automatic model_reset();
        m_level = 0;
        m_duty  = 0;
        m_kick  = 0;
        m_ramp  = 1'b0;
        m_pend  = 1'b0;
        m_pwm   = 1'b0;
    endtask

    // Advance the model across one clock edge given the inputs sampled at that edge
    task automatic model_edge(input bit r, input int c, input bit u, input bit o);
        int tgt;
        int nl;
        if (r) begin
            model_reset();
            return;
        end
        m_pwm = (c < m_duty);
        if (c == PERIOD_MAX) begin
            tgt = target_of(m_level);
            if (m_kick > 0) begin
                m_kick = (m_level == 0) ? 0 : m_kick - 1;
                if (m_kick == 0) begin
                    m_duty = approach(m_duty, tgt);
                    m_ramp = (m_duty != tgt);
                end
            end else if (!m_ramp && m_pend && m_duty == 0 && m_level != 0) begin
                m_duty = KICK_DUTY;
                m_kick = KICK_PERIODS;
            end else begin
                m_duty = approach(m_duty, tgt);
                m_ramp = (m_duty != tgt);
            end
            m_pend = 1'b0;
        end
        nl = o ? 0 : (u ? (m_level + 1) % 4 : m_level);
        if (m_level == 0 && nl != 0) m_pend = 1'b1;
        m_level = nl;
    endtask

    task automatic tick();
        obs_t e;
        @(posedge clk);
        #1;
        model_edge(rst, int'(cnt), up, off);
        e.level = m_level;
        e.duty  = m_duty;
        e.busy  = (m_kick > 0) || m_ramp;
        e.pwm   = m_pwm;
        exp_q.push_back(e);
        cnt = (cnt == 10'(PERIOD_MAX)) ? 10'd0 : cnt + 10'd1;
        up  = 1'b0;
        off = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int c);
        int guard;
        guard = 0;
        while (int'(cnt) != c && guard < 2000) begin
            tick();
            guard++;
        end
    endtask

    task automatic expect_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Walk boundary by boundary until the model reports the fan has reached its level's duty
    task automatic settle();
        int guard;
        guard = 0;
        do begin
            run_to(PERIOD_MAX);
            tick();
            guard++;
        end while ((m_kick > 0 || m_ramp || m_pend || m_duty != target_of(m_level)) && guard < 30);
        if (guard >= 30) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: got %0d boundaries, expected fewer than 30", guard);
        end
    endtask

    task automatic pulse_at(input int c, input bit u, input bit o);
        run_to(c);
        up  = u;
        off = o;
        tick();
    endtask

    // Scoreboard monitor: one expected observation per clock edge, compared mid-cycle
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (int'(level) != e.level || int'(duty) != e.duty || busy != e.busy || pwm != e.pwm) begin
                    errors++;
                    $display("FAIL cycle_obs t=%0t: got level=%0d duty=%0d busy=%0d pwm=%0d, expected level=%0d duty=%0d busy=%0d pwm=%0d",
                             $time, level, duty, busy, pwm, e.level, e.duty, e.busy, e.pwm);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        up     = 1'b0;
        off    = 1'b0;
        cnt    = 10'd0;
        model_reset();
        run(3);
        @(negedge clk);
        #2 rst = 1'b0;

        // Quiet after reset: everything stays at zero
        run(1200);

        // Kick-start from OFF, then level cycling LOW -> HIGH
        pulse_at(100, 1'b1, 1'b0);
        expect_eq("level_after_pulse", int'(level), 1);
        run_to(PERIOD_MAX);
        tick();
        expect_eq("kick_duty", int'(duty), KICK_DUTY);
        expect_eq("kick_busy", int'(busy), 1);
        settle();
        expect_eq("low_duty", int'(duty), 300);
        pulse_at(200, 1'b1, 1'b0);
        pulse_at(210, 1'b1, 1'b0);
        expect_eq("high_level", int'(level), 3);
        settle();
        expect_eq("high_duty", int'(duty), 900);

        // Asynchronous reset while running at HIGH
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        expect_eq("reset_pwm", int'(pwm), 0);
        expect_eq("reset_duty", int'(duty), 0);
        expect_eq("reset_level", int'(level), 0);
        expect_eq("reset_busy", int'(busy), 0);
        run(3);
        @(negedge clk);
        #2 rst = 1'b0;
        run(1100);

        // Off pulse during the second kick period aborts the kick
        pulse_at(300, 1'b1, 1'b0);
        run_to(PERIOD_MAX);
        tick();
        run_to(PERIOD_MAX);
        tick();
        pulse_at(500, 1'b0, 1'b1);
        run_to(PERIOD_MAX);
        tick();
        expect_eq("kick_abort_duty", int'(duty), SOFT ? KICK_DUTY - RAMP_STEP : 0);
        settle();
        expect_eq("abort_final_duty", int'(duty), 0);

        // Simultaneous speed-up and off while MID
        pulse_at(50, 1'b1, 1'b0);
        settle();
        pulse_at(60, 1'b1, 1'b0);
        settle();
        pulse_at(70, 1'b1, 1'b1);
        expect_eq("simul_level", int'(level), 0);
        settle();
        expect_eq("simul_duty", int'(duty), 0);

        // Pulses at mid-period and exactly on the boundary count
        pulse_at(500, 1'b1, 1'b0);
        pulse_at(PERIOD_MAX, 1'b1, 1'b0);
        expect_eq("boundary_kick_duty", int'(duty), KICK_DUTY);
        settle();
        expect_eq("boundary_final_duty", int'(duty), 600);

        // Random button traffic, biased toward boundary-aligned pulses
        for (int i = 0; i < RAND_CYCLES; i++) begin
            int r;
            r = int'($urandom_range(0, 1999));
            up  = (r == 0) || (r == 2) || (cnt == 10'(PERIOD_MAX) && $urandom_range(0, 9) == 0);
            off = (r == 1) || (r == 2);
            tick();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fan_speed_controller.md
# fan_speed_controller

Fan speed controller that drives the PWM compare for the fan output stage. It keeps a user speed level (OFF/LOW/MID/HIGH) set by debounced button pulses. It applies a kick-start burst when the fan leaves OFF, and moves the applied duty toward the level's target only at PWM period boundaries. It sits between the button debouncers and the fan output pin, and consumes the free-running 0..999 period counter.

## Interface
- PERIOD_MAX, 999: terminal count of the external period counter; a period boundary is `i_counter == PERIOD_MAX`.
- DUTY_LOW, 300: target duty for LOW.
- DUTY_MID, 600: target duty for MID.
- DUTY_HIGH, 900: target duty for HIGH.
- RAMP_STEP, 50: maximum duty change per period boundary in soft-start mode.
- KICK_DUTY, 999: duty applied during kick-start.
- KICK_PERIODS, 4: number of full periods held at KICK_DUTY; must be ≥ 1.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_counter  in  10  period counter value, 0..PERIOD_MAX, advancing once per i_clk.
- i_speed_up  in  1  single-cycle pulse that advances the level.
- i_off  in  1  single-cycle pulse that forces the level to OFF.
- o_pwm  out  1  registered fan drive.
- o_level  out  2  current level: 0 = OFF, 1 = LOW, 2 = MID, 3 = HIGH.
- o_duty  out  10  applied duty register.
- o_busy  out  1  high while in KICK or RAMP.

## Operation
- Reset values: all outputs 0, level OFF, duty 0, kick count 0, state IDLE.
- Level FSM, updated on the clock edge after a pulse:
  - i_speed_up steps OFF→LOW→MID→HIGH→OFF.
  - i_off forces OFF.
  - If both pulses arrive in the same cycle, i_off wins.
- Target duty is a combinational function of the level: 0, DUTY_LOW, DUTY_MID or DUTY_HIGH.
- Duty FSM changes state and duty only on clock edges where i_counter == PERIOD_MAX. On all other cycles, duty and state hold.
- IDLE:
  - Leaving OFF is pending (the level left OFF since the last boundary, while duty == 0) → load duty = KICK_DUTY, set kick count = KICK_PERIODS, go to KICK.
  - Otherwise, duty ≠ target → go to RAMP and apply one step at this same boundary.
- KICK:
  - Each boundary decrements the kick count.
  - When the count reaches 0, go to RAMP. The first step is taken at that boundary, so the kick lasts exactly KICK_PERIODS full periods.
  - Level OFF at a boundary → abandon the kick, go to RAMP, and step toward 0 at that boundary.
  - Level changes between non-OFF values during KICK only update the target; the kick continues.
- RAMP step:
  - If duty < target: duty = min(duty + RAMP_STEP, target).
  - If duty > target: duty = max(duty − RAMP_STEP, target).
  - Compute in 11 bits so the result never wraps past 0 or 1023.
  - When the new duty equals the target, go to IDLE.
- PWM: o_pwm is registered as (i_counter < duty).
  - duty 0 → o_pwm constant 0.
  - duty 999 → o_pwm high for counts 0..998 and low at 999.
- o_busy = (state ≠ IDLE).
- o_duty is the duty register.

## Timing
- Pulse to o_level: 1 cycle.
- Duty change to o_pwm: the new duty is latched at the edge where count 999 is sampled. It first affects o_pwm on the edge that samples count 0, so there are no partial periods.
- Level change to the first duty change: at the next boundary, at most PERIOD_MAX + 1 cycles.
- Soft-start ramp 0→900 after the kick: ⌈|KICK_DUTY − target| / RAMP_STEP⌉ periods.
- Reset asserted mid-kick or mid-ramp: all outputs clear asynchronously. o_pwm is 0 within the reset-assert time. After release, the block restarts in IDLE/OFF.

## Configuration
- FAN_SOFTSTART_EN defined: RAMP steps by RAMP_STEP as described above.
- FAN_SOFTSTART_EN undefined:
  - RAMP loads duty = target in a single boundary, then returns to IDLE.
  - KICK is unchanged.
  - RAMP_STEP is ignored.

## Test plan
- Reset check: assert i_reset during HIGH at duty 900 → o_pwm, o_duty, o_level and o_busy read 0 immediately. After release they stay 0 until a pulse arrives.
- Kick-start, soft start enabled: one i_speed_up from OFF →
  - o_level = 1 one cycle later.
  - o_duty = 999 from the next boundary for 4 periods.
  - Then the duty steps 949, 899, …, 349, 300; o_busy falls at the 300 boundary.
- Level cycling: from LOW at 300, pulse i_speed_up twice →
  - o_level = 3.
  - Duty ramps in 50-count steps to 900.
  - The o_pwm high count per period equals the o_duty applied in that period.
- Off-during-kick: i_off during the second kick period → at the next boundary the kick aborts and the duty steps down by 50 from 999 to 0. With the macro undefined, the duty instead drops to 0 at that boundary.
- Simultaneous pulses: i_speed_up and i_off in the same cycle while MID → o_level = 0, and the duty ramps to 0.
- Boundary alignment: pulse i_speed_up at count 500 and at count 999 → the duty changes only on the edge sampling 999, and o_pwm never shows a partial-period glitch.
